// File: rtl/seg7_scan_driver_pkg.sv
// Shared constants, state encoding and small decode helpers for the
// four-digit multiplexed 7-segment scan driver.
package seg7_scan_driver_pkg;

    // Active-low segment pattern with every segment off.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low anode word with every digit deselected.
    localparam logic [3:0] AN_OFF = 4'b1111;

    // Digit slot indices; digit 0 is the rightmost (seconds, low).
    localparam logic [1:0] DIG_SEC_L = 2'd0;
    localparam logic [1:0] DIG_SEC_H = 2'd1;
    localparam logic [1:0] DIG_MIN_L = 2'd2;
    localparam logic [1:0] DIG_MIN_H = 2'd3;

    // Per-slot phase: anti-ghosting blank window, then the lit window.
    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } scan_state_e;

    // Pick one 7-bit digit pattern out of the packed 28-bit bus.
    function automatic logic [6:0] digit_seg(input logic [27:0] seg_bus,
                                             input logic [1:0]  idx);
        logic [6:0] pat;
        pat = SEG_BLANK;
        case (idx)
            DIG_SEC_L: pat = seg_bus[6:0];
            DIG_SEC_H: pat = seg_bus[13:7];
            DIG_MIN_L: pat = seg_bus[20:14];
            DIG_MIN_H: pat = seg_bus[27:21];
        endcase
        return pat;
    endfunction

    // Active-low one-cold anode select for a digit index.
    function automatic logic [3:0] anode_sel(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/seg7_scan_driver.sv
// Time-multiplexes four active-low 7-segment digits onto one segment bus.
// Each digit slot is SCAN_DIV cycles long: BLANK_CYCLES with all anodes off
// (suppresses ghosting while the bus changes), then the digit is lit.
// The digit pattern and decimal point are captured once at the start of the
// slot so a mid-slot input change never tears the displayed digit.
// All outputs are registered and computed from the next-state values, so the
// outputs seen in a cycle always agree with cnt/digit/state held that cycle.
module seg7_scan_driver
    import seg7_scan_driver_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [27:0] seg_in,
    input  logic [3:0]  dp_mask,
    output logic [6:0]  seg_out,
    output logic        dp_out,
    output logic [3:0]  an_out,
    output logic        frame_tick
);

    localparam int            CW        = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
    localparam bit            NO_BLANK  = (BLANK_CYCLES == 0);

    // Scan position and phase.
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    digit_q, digit_d;
    scan_state_e   state_q, state_d;

    // Low for the one cycle after a disabled period; the first enabled
    // cycle is then held at digit0/cnt0 so the restart is a full slot.
    logic          run_q, run_d;

    // Per-slot snapshot of the digit being shown.
    logic [6:0]    snap_seg_q, snap_seg_d;
    logic          snap_dp_q, snap_dp_d;
    logic          snap_load;
    logic          wrap;

    // Registered outputs.
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [3:0]    an_q, an_d;
    logic          tick_q, tick_d;

    // Next scan position and FSM state.
    always_comb begin
        cnt_d   = cnt_q;
        digit_d = digit_q;
        state_d = state_q;
        run_d   = run_q;
        wrap    = 1'b0;
        if (!enable) begin
            // Dark and parked at the start of digit0.
            cnt_d   = '0;
            digit_d = DIG_SEC_L;
            state_d = ST_BLANK;
            run_d   = 1'b0;
        end else if (!run_q) begin
            // First enabled cycle after a dark period: restart at digit0 cnt0.
            cnt_d   = '0;
            digit_d = DIG_SEC_L;
            state_d = ST_BLANK;
            run_d   = 1'b1;
        end else begin
            if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                digit_d = digit_q + 2'd1;
                wrap    = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
            state_d = (cnt_d < BLANK_END) ? ST_BLANK : ST_ON;
        end
    end

    // Snapshot capture. Normally taken while sitting at cnt0 (always a blank
    // cycle when blanking is enabled, and after any restart). With no
    // blanking, cnt0 of a running slot is already lit, so the capture moves
    // to the wrap edge that enters it.
    always_comb begin
        snap_load  = enable && run_q &&
                     (((cnt_q == '0) && (state_q == ST_BLANK)) || (NO_BLANK && wrap));
        snap_seg_d = snap_seg_q;
        snap_dp_d  = snap_dp_q;
        if (snap_load) begin
            snap_seg_d = digit_seg(seg_in, digit_d);
            snap_dp_d  = dp_mask[digit_d];
        end
    end

    // Output decode from the state that will be held next cycle.
    always_comb begin
        seg_d  = SEG_BLANK;
        dp_d   = 1'b1;
        an_d   = AN_OFF;
        tick_d = 1'b0;
        case (state_d)
            ST_BLANK: begin
            end
            ST_ON: begin
                an_d   = anode_sel(digit_d);
                seg_d  = snap_seg_d;
                dp_d   = ~snap_dp_d;
                tick_d = (digit_d == DIG_MIN_H) && (cnt_d == CNT_LAST);
            end
        endcase
    end

    // State, snapshot and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            digit_q    <= DIG_SEC_L;
            state_q    <= ST_BLANK;
            run_q      <= 1'b1;
            snap_seg_q <= SEG_BLANK;
            snap_dp_q  <= 1'b0;
            seg_q      <= SEG_BLANK;
            dp_q       <= 1'b1;
            an_q       <= AN_OFF;
            tick_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            digit_q    <= digit_d;
            state_q    <= state_d;
            run_q      <= run_d;
            snap_seg_q <= snap_seg_d;
            snap_dp_q  <= snap_dp_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            an_q       <= an_d;
            tick_q     <= tick_d;
        end
    end

    assign seg_out    = seg_q;
    assign dp_out     = dp_q;
    assign an_out     = an_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver with SCAN_DIV=8, BLANK_CYCLES=2.
// The driver pushes the expected output word for every cycle into exp_q;
// a negedge monitor pops and compares, and records what it saw so that
// hand-computed directed checks can be made at the end.
module tb_seg7_scan_driver;

    localparam int SCAN_DIV     = 8;
    localparam int BLANK_CYCLES = 2;
    localparam int MAX_CYC      = 512;

    localparam logic [27:0] PAT   = {7'h24, 7'h01, 7'h4F, 7'h12};
    localparam logic [27:0] PAT_B = {7'h24, 7'h01, 7'h4F, 7'h00};

    // Clock / DUT signals
    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [27:0] seg_in;
    logic [3:0]  dp_mask;
    logic [6:0]  seg_out;
    logic        dp_out;
    logic [3:0]  an_out;
    logic        frame_tick;

    // Scoreboard: {an[3:0], seg[6:0], dp, tick}
    logic [12:0] exp_q[$];
    logic [12:0] obs [MAX_CYC];
    logic [12:0] mon_exp;
    logic [12:0] mon_act;
    int          mon_cyc = 0;
    int          drv_cyc = 0;
    int          n_total = 0;
    int          n_bad   = 0;

    // Reference model state: cycles since restart and per-digit snapshots.
    int          m_pos;
    bit          m_run;
    logic [6:0]  m_seg [4];
    logic        m_dp  [4];

    int          base_a;
    int          base_b;
    int          base_c;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .SCAN_DIV    (SCAN_DIV),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .seg_in    (seg_in),
        .dp_mask   (dp_mask),
        .seg_out   (seg_out),
        .dp_out    (dp_out),
        .an_out    (an_out),
        .frame_tick(frame_tick)
    );

    function automatic logic [12:0] model_out();
        int         slot;
        int         ph;
        logic [3:0] an_v;
        if (!m_run) return {4'hF, 7'h7F, 1'b1, 1'b0};
        slot = (m_pos / SCAN_DIV) % 4;
        ph   = m_pos % SCAN_DIV;
        if (ph < BLANK_CYCLES) return {4'hF, 7'h7F, 1'b1, 1'b0};
        an_v = ~(4'b0001 << slot);
        return {an_v, m_seg[slot], ~m_dp[slot], (slot == 3 && ph == SCAN_DIV - 1)};
    endfunction

    // Driver: one call per clock cycle. Pushes the expected outputs of the
    // current cycle, applies this cycle's inputs, then advances the model.
    task automatic step(input logic r, input logic e, input logic [27:0] s, input logic [3:0] d);
        int slot;
        int ph;
        exp_q.push_back(model_out());
        rst     = r;
        enable  = e;
        seg_in  = s;
        dp_mask = d;
        slot = (m_pos / SCAN_DIV) % 4;
        ph   = m_pos % SCAN_DIV;
        if (r) begin
            m_run = 1'b1;
            m_pos = 0;
        end else if (!e) begin
            m_run = 1'b0;
            m_pos = 0;
        end else if (!m_run) begin
            m_run = 1'b1;
            m_pos = 0;
        end else begin
            if (ph == 0) begin
                m_seg[slot] = s[slot*7 +: 7];
                m_dp[slot]  = d[slot];
            end
            m_pos = m_pos + 1;
        end
        drv_cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int got, input int want);
        n_total++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Monitor: compare every cycle's outputs against the queued expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_act = {an_out, seg_out, dp_out, frame_tick};
            if (mon_cyc < MAX_CYC) obs[mon_cyc] = mon_act;
            n_total++;
            if (mon_act !== mon_exp) begin
                n_bad++;
                $display("FAIL out@cyc%0d: got an=%b seg=%h dp=%b tick=%b want an=%b seg=%h dp=%b tick=%b",
                         mon_cyc, mon_act[12:9], mon_act[8:2], mon_act[1], mon_act[0],
                         mon_exp[12:9], mon_exp[8:2], mon_exp[1], mon_exp[0]);
            end
            mon_cyc++;
        end
    end

    function automatic int f_an(input int g);
        return int'(obs[g][12:9]);
    endfunction
    function automatic int f_seg(input int g);
        return int'(obs[g][8:2]);
    endfunction
    function automatic int f_dp(input int g);
        return int'(obs[g][1]);
    endfunction
    function automatic int f_tick(input int g);
        return int'(obs[g][0]);
    endfunction

    initial begin
        rst     = 1'b1;
        enable  = 1'b1;
        seg_in  = PAT;
        dp_mask = 4'h0;
        m_run   = 1'b1;
        m_pos   = 0;
        for (int i = 0; i < 4; i++) begin
            m_seg[i] = 7'h7F;
            m_dp[i]  = 1'b0;
        end
        @(posedge clk);
        #1;

        // Phase A: reset hold, normal scan, free run, mid-slot input change.
        repeat (5) step(1'b1, 1'b1, PAT, 4'h0);
        base_a = drv_cyc;
        for (int i = 0; i < 100; i++) step(1'b0, 1'b1, (i >= 4) ? PAT_B : PAT, 4'h0);

        // Phase B: enable drop at 20, restore at 40.
        step(1'b1, 1'b1, PAT, 4'h0);
        base_b = drv_cyc;
        for (int i = 0; i < 60; i++) step(1'b0, !(i >= 20 && i < 40), PAT, 4'h0);

        // Phase C: decimal point on digit2, reset pulse mid-slot at 13.
        step(1'b1, 1'b1, PAT, 4'b0100);
        base_c = drv_cyc;
        for (int i = 0; i < 40; i++) step(i == 13, 1'b1, PAT, 4'b0100);

        @(negedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);

        // Directed, hand-computed checks.
        for (int r = 1; r <= 5; r++) begin
            chk($sformatf("rst_an@%0d", r), f_an(base_a - r), 'hF);
            chk($sformatf("rst_seg@%0d", r), f_seg(base_a - r), 'h7F);
            chk($sformatf("rst_dp@%0d", r), f_dp(base_a - r), 1);
            chk($sformatf("rst_tick@%0d", r), f_tick(base_a - r), 0);
        end
        for (int r = 0; r < 100; r++)
            chk($sformatf("A_tick@%0d", r), f_tick(base_a + r), (r == 31 || r == 63 || r == 95) ? 1 : 0);
        chk("A_an@0", f_an(base_a + 0), 'hF);
        chk("A_an@1", f_an(base_a + 1), 'hF);
        chk("A_an@2", f_an(base_a + 2), 'hE);
        chk("A_seg@2", f_seg(base_a + 2), 'h12);
        chk("A_seg@7", f_seg(base_a + 7), 'h12);
        chk("A_an@8", f_an(base_a + 8), 'hF);
        chk("A_an@10", f_an(base_a + 10), 'hD);
        chk("A_seg@10", f_seg(base_a + 10), 'h4F);
        chk("A_an@18", f_an(base_a + 18), 'hB);
        chk("A_seg@18", f_seg(base_a + 18), 'h01);
        chk("A_an@26", f_an(base_a + 26), 'h7);
        chk("A_seg@26", f_seg(base_a + 26), 'h24);
        chk("A_an@32", f_an(base_a + 32), 'hF);
        chk("A_an@34", f_an(base_a + 34), 'hE);
        chk("A_seg@34", f_seg(base_a + 34), 'h00);

        chk("B_an@20", f_an(base_b + 20), 'hB);
        chk("B_seg@20", f_seg(base_b + 20), 'h01);
        for (int r = 21; r <= 42; r++) begin
            chk($sformatf("B_an@%0d", r), f_an(base_b + r), 'hF);
            chk($sformatf("B_tick@%0d", r), f_tick(base_b + r), 0);
        end
        for (int r = 43; r <= 48; r++) begin
            chk($sformatf("B_an@%0d", r), f_an(base_b + r), 'hE);
            chk($sformatf("B_seg@%0d", r), f_seg(base_b + r), 'h12);
        end
        chk("B_an@49", f_an(base_b + 49), 'hF);

        chk("C_dp@2", f_dp(base_c + 2), 1);
        chk("C_an@13", f_an(base_c + 13), 'hD);
        chk("C_dp@13", f_dp(base_c + 13), 1);
        chk("C_an@14", f_an(base_c + 14), 'hF);
        chk("C_an@16", f_an(base_c + 16), 'hE);
        chk("C_dp@16", f_dp(base_c + 16), 1);
        chk("C_an@32", f_an(base_c + 32), 'hB);
        chk("C_dp@32", f_dp(base_c + 32), 0);
        chk("C_dp@37", f_dp(base_c + 37), 0);
        chk("C_an@38", f_an(base_c + 38), 'hF);
        chk("C_dp@38", f_dp(base_c + 38), 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
